// File: rtl/lab5_pkg.sv
// Shared definitions for the lab5 interval timer.
// Widths of the count and prescaler paths, plus matching vector typedefs.
package lab5_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PSC_W = 5;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PSC_W-1:0] psc_t;

endpackage

// File: rtl/lab5_g61_p2_prescaler.sv
// Clock prescaler for the interval timer.
// Counts clocks up to psc and emits a registered one-cycle tick on each expiry.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset
//   clr    - synchronous clear; holds the prescaler at zero while high
//   psc    - prescaler setting; tick period is psc+1 clocks
//   tick   - registered pulse, high in the cycle after an expiry edge
//   expire - combinational strobe, high when the coming edge is an expiry edge
module lab5_g61_p2_prescaler #(
    parameter int unsigned PSC_W = lab5_pkg::PSC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick,
    output logic             expire
);

    logic [PSC_W-1:0] pcnt_q, pcnt_d;
    logic             tick_q, tick_d;

    // >= rather than == so a psc lowered below the running count expires at once
    // instead of waiting for the counter to roll over.
    assign expire = !clr && (pcnt_q >= psc);

    always_comb begin
        pcnt_d = pcnt_q;
        tick_d = 1'b0;
        if (clr) begin
            pcnt_d = '0;
        end else if (expire) begin
            pcnt_d = '0;
            tick_d = 1'b1;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/lab5_g61_p2_down_counter.sv
// Prescaled down counter with automatic reload, used as an interval timer.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset (clears count and prescaler)
//   en     - load strobe: loads cnt from reload and holds the prescaler cleared
//   psc    - prescaler setting; cnt steps every psc+1 clocks
//   reload - value loaded on en and on each wrap from zero
//   tick   - registered one-cycle pulse per prescaler expiry
//   done   - high whenever cnt is zero
//   cnt    - current count
module lab5_g61_p2_down_counter #(
    parameter int unsigned CNT_W = lab5_pkg::CNT_W,
    parameter int unsigned PSC_W = lab5_pkg::PSC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PSC_W-1:0] psc,
    input  logic [CNT_W-1:0] reload,
    output logic             tick,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    import lab5_pkg::*;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire;

    lab5_g61_p2_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clr    (en),
        .psc    (psc),
        .tick   (tick),
        .expire (expire)
    );

    // reload is only sampled on a load or a wrap, so mid-count changes wait for
    // the next wrap. The wrap goes to reload, never past zero.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = reload;
        end else if (expire) begin
            if (cnt_q == '0) begin
                cnt_d = reload;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == '0);

endmodule

// File: tb/tb_lab5_g61_p2_down_counter.sv
// Self-checking bench for the prescaled down counter.
// A behavioural model tracks clocks elapsed in the current tick period and the
// count; a compare process checks every cycle, and directed literal checks pin
// the model at the points the timer behaviour is easy to hand-compute.
module tb_lab5_g61_p2_down_counter;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  psc;
    logic [15:0] reload;
    logic        tick;
    logic        done;
    logic [15:0] cnt;

    int n_vec;
    int n_err;

    lab5_g61_p2_down_counter u_dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .psc    (psc),
        .reload (reload),
        .tick   (tick),
        .done   (done),
        .cnt    (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: clocks elapsed since the last tick/load, current count, tick.
    int unsigned m_elapsed;
    int unsigned m_cnt;
    bit          m_tick;
    bit          m_valid;

    initial begin
        m_valid   = 1'b0;
        m_elapsed = 0;
        m_cnt     = 0;
        m_tick    = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_elapsed = 0;
            m_cnt     = 0;
            m_tick    = 1'b0;
            m_valid   = 1'b1;
        end else if (en) begin
            m_elapsed = 0;
            m_cnt     = int'(reload);
            m_tick    = 1'b0;
        end else if (m_elapsed >= int'(psc)) begin
            // Period over: emit a tick and step the count, wrapping to reload.
            m_elapsed = 0;
            m_tick    = 1'b1;
            m_cnt     = (m_cnt == 0) ? int'(reload) : m_cnt - 1;
        end else begin
            m_elapsed = m_elapsed + 1;
            m_tick    = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_tick", {31'd0, tick}, {31'd0, m_tick});
            chk("model_done", {31'd0, done}, {31'd0, (m_cnt == 0)});
            chk("model_cnt", {16'd0, cnt}, m_cnt);
        end
    end

    initial begin
        int done_hi;
        int exp_seq[5];
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b1;
        en     = 1'b0;
        psc    = 5'd7;
        reload = 16'd10;
        repeat (2) @(negedge clk);
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd1);
        chk("rst_tick", {31'd0, tick}, 32'd0);

        // Release: first step on the 8th edge wraps 0 -> 10.
        reset = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_tick_cnt", {16'd0, cnt}, 32'd0);
        chk("pre_tick_tick", {31'd0, tick}, 32'd0);
        @(negedge clk);
        chk("first_tick", {31'd0, tick}, 32'd1);
        chk("first_cnt", {16'd0, cnt}, 32'd10);
        chk("first_done", {31'd0, done}, 32'd0);

        // One full wrap period is 11*8 = 88 clocks, done high for 8 of them.
        done_hi = 0;
        repeat (88) begin
            @(negedge clk);
            if (done) done_hi++;
        end
        chk("done_width", done_hi, 32'd8);
        chk("wrap_cnt", {16'd0, cnt}, 32'd10);
        repeat (150) @(negedge clk);

        // Mid-count reload change only takes effect at the next wrap.
        reload = 16'd7;
        repeat (200) @(negedge clk);

        // Load strobe.
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("load_cnt", {16'd0, cnt}, 32'd7);
        chk("load_tick", {31'd0, tick}, 32'd0);
        repeat (7) @(negedge clk);
        chk("load_hold", {16'd0, cnt}, 32'd7);
        @(negedge clk);
        chk("load_step", {16'd0, cnt}, 32'd6);
        chk("load_step_tick", {31'd0, tick}, 32'd1);

        // Reset beats en.
        reset = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        chk("rst_en_cnt", {16'd0, cnt}, 32'd0);
        chk("rst_en_done", {31'd0, done}, 32'd1);

        // psc = 0: count steps every clock.
        psc    = 5'd0;
        reload = 16'd3;
        en     = 1'b1;
        @(negedge clk);
        en = 1'b0;
        exp_seq = '{3, 2, 1, 0, 3};
        for (int i = 0; i < 5; i++) begin
            chk("psc0_seq", {16'd0, cnt}, exp_seq[i]);
            @(negedge clk);
        end
        chk("psc0_tick", {31'd0, tick}, 32'd1);

        // reload = 0: done stays high, tick keeps pulsing.
        psc    = 5'd1;
        reload = 16'd0;
        en     = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("reload0_done", {31'd0, done}, 32'd1);
        end

        // Lower psc while the prescaler is above the new setting.
        psc    = 5'd31;
        reload = 16'd5;
        en     = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("psc_hi_cnt", {16'd0, cnt}, 32'd5);
        psc = 5'd2;
        @(negedge clk);
        chk("psc_drop_tick", {31'd0, tick}, 32'd1);
        chk("psc_drop_cnt", {16'd0, cnt}, 32'd4);
        repeat (2) @(negedge clk);
        chk("psc_drop_gap", {31'd0, tick}, 32'd0);
        @(negedge clk);
        chk("psc_drop_next", {31'd0, tick}, 32'd1);
        chk("psc_drop_cnt2", {16'd0, cnt}, 32'd3);
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
